// File: rtl/serial_pkg.sv
// Shared definitions for the single-bit serial link (transmitter and receiver).
// Holds the frame state encoding, the line levels and default frame geometry.
package serial_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    localparam logic IDLE_LVL  = 1'b1;
    localparam logic START_LVL = 1'b0;

    localparam int DEFAULT_DATA_W       = 8;
    localparam int DEFAULT_CLKS_PER_BIT = 4;

endpackage

// File: rtl/serial_tx_bit_timer.sv
// bit_timer: divides clk into serial bit periods.
// Ports:
//   clk       - system clock
//   rst       - asynchronous active-high reset
//   clr_i     - synchronous clear, held while the transmitter is idle
//   bit_end_o - high in the last cycle of every bit period
module bit_timer
    import serial_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    output logic bit_end_o
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (clr_i || (cnt_q == LAST)) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // Suppressed while cleared so an idle transmitter never sees a stray boundary.
    assign bit_end_o = (cnt_q == LAST) && !clr_i;

endmodule

// File: rtl/serial_tx.sv
// serial_tx: parallel-to-serial frame transmitter.
// Frame: start bit (0), DATA_W data bits LSB first, optional even parity,
// stop bit (1). Each bit is held for CLKS_PER_BIT clocks.
// Ports:
//   clk     - system clock, rising edge
//   rst     - asynchronous active-high reset
//   data_in - word to send, captured on the valid&&ready edge
//   valid   - requester has a word on data_in
//   ready   - transmitter idle, able to accept a word
//   tx      - serial line, idles high
//   done    - one-cycle pulse when the stop bit completes
module serial_tx
    import serial_pkg::*;
#(
    parameter int DATA_W       = DEFAULT_DATA_W,
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int PARITY_EN    = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] data_in,
    input  logic              valid,
    output logic              ready,
    output logic              tx,
    output logic              done
);

    localparam int BCW = $clog2(DATA_W + 1);
    localparam logic [BCW-1:0] LAST_BIT = BCW'(DATA_W - 1);

    state_t            state_q;
    logic [DATA_W-1:0] shift_q;
    logic [DATA_W-1:0] shift_nx;
    logic [BCW-1:0]    bit_cnt_q;
    logic              par_q;
    logic              tx_q;
    logic              ready_q;
    logic              done_q;
    logic              bit_end;

    bit_timer #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_bit_timer (
        .clk       (clk),
        .rst       (rst),
        .clr_i     (state_q == ST_IDLE),
        .bit_end_o (bit_end)
    );

    assign shift_nx = shift_q >> 1;

    // tx is loaded one edge ahead with the level of the bit being entered,
    // so the line is registered yet aligned with the state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            par_q     <= 1'b0;
            tx_q      <= IDLE_LVL;
            ready_q   <= 1'b1;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (valid && ready_q) begin
                        shift_q   <= data_in;
                        par_q     <= ^data_in;
                        bit_cnt_q <= '0;
                        tx_q      <= START_LVL;
                        ready_q   <= 1'b0;
                        state_q   <= ST_START;
                    end
                end
                ST_START: begin
                    if (bit_end) begin
                        tx_q    <= shift_q[0];
                        state_q <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (bit_end) begin
                        if (bit_cnt_q == LAST_BIT) begin
                            bit_cnt_q <= '0;
                            if (PARITY_EN != 0) begin
                                tx_q    <= par_q;
                                state_q <= ST_PARITY;
                            end else begin
                                tx_q    <= IDLE_LVL;
                                state_q <= ST_STOP;
                            end
                        end else begin
                            shift_q   <= shift_nx;
                            tx_q      <= shift_nx[0];
                            bit_cnt_q <= bit_cnt_q + 1'b1;
                        end
                    end
                end
                ST_PARITY: begin
                    if (bit_end) begin
                        tx_q    <= IDLE_LVL;
                        state_q <= ST_STOP;
                    end
                end
                ST_STOP: begin
                    if (bit_end) begin
                        ready_q <= 1'b1;
                        done_q  <= 1'b1;
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    tx_q    <= IDLE_LVL;
                    ready_q <= 1'b1;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign ready = ready_q;
    assign tx    = tx_q;
    assign done  = done_q;

endmodule

// File: tb/tb_serial_tx.sv
module tb_serial_tx;

    logic       clk;
    logic       rst;
    logic [7:0] data0, data1;
    logic       valid0, valid1;
    logic       ready0, ready1;
    logic       tx0, tx1;
    logic       done0, done1;

    int n_vec;
    int n_err;
    int done_cnt0;
    int done_cnt1;

    serial_tx #(.DATA_W(8), .CLKS_PER_BIT(4), .PARITY_EN(0)) dut0 (
        .clk(clk), .rst(rst), .data_in(data0), .valid(valid0),
        .ready(ready0), .tx(tx0), .done(done0)
    );

    serial_tx #(.DATA_W(8), .CLKS_PER_BIT(4), .PARITY_EN(1)) dut1 (
        .clk(clk), .rst(rst), .data_in(data1), .valid(valid1),
        .ready(ready1), .tx(tx1), .done(done1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (done0) done_cnt0++;
        if (done1) done_cnt1++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic tx_of(input int s);
        return (s == 1) ? tx1 : tx0;
    endfunction
    function automatic logic ready_of(input int s);
        return (s == 1) ? ready1 : ready0;
    endfunction
    function automatic logic done_of(input int s);
        return (s == 1) ? done1 : done0;
    endfunction

    // Caller presents valid/data before the next edge, which is the handshake
    // edge. After it, data is replaced by next_d and valid by keep_valid.
    // Every cycle of the frame is checked, then the ready/done cycle.
    task automatic expect_frame(input int sel, input logic [7:0] d, input logic exp_par,
                                input logic [7:0] next_d, input logic keep_valid);
        int   nbits;
        logic lvl;
        nbits = (sel == 1) ? 11 : 10;
        @(posedge clk);
        #1;
        if (sel == 1) begin
            data1  = next_d;
            valid1 = keep_valid;
        end else begin
            data0  = next_d;
            valid0 = keep_valid;
        end
        for (int b = 0; b < nbits; b++) begin
            if (b == 0)              lvl = 1'b0;
            else if (b <= 8)         lvl = d[b-1];
            else if (b == nbits - 1) lvl = 1'b1;
            else                     lvl = exp_par;
            for (int c = 0; c < 4; c++) begin
                @(negedge clk);
                check($sformatf("tx%0d bit%0d cyc%0d", sel, b, c), tx_of(sel), lvl);
                check($sformatf("ready%0d low bit%0d", sel, b), ready_of(sel), 0);
                check($sformatf("done%0d low bit%0d", sel, b), done_of(sel), 0);
            end
        end
        @(negedge clk);
        check($sformatf("ready%0d after frame", sel), ready_of(sel), 1);
        check($sformatf("done%0d after frame", sel), done_of(sel), 1);
        check($sformatf("tx%0d idle after frame", sel), tx_of(sel), 1);
    endtask

    initial begin
        int dc;
        n_vec  = 0;
        n_err  = 0;
        done_cnt0 = 0;
        done_cnt1 = 0;
        rst    = 1'b1;
        valid0 = 1'b1;
        valid1 = 1'b1;
        data0  = 8'hA5;
        data1  = 8'h07;

        // reset held with valid asserted: nothing may start
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("rst tx0", tx0, 1);
            check("rst ready0", ready0, 1);
            check("rst done0", done0, 0);
            check("rst tx1", tx1, 1);
            check("rst ready1", ready1, 1);
            check("rst done1", done1, 0);
        end
        valid0 = 1'b0;
        valid1 = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("idle tx0", tx0, 1);
        check("idle ready0", ready0, 1);

        // single frame A5: 0,1,0,1,0,0,1,0,1,1; data_in scrambled after handshake
        valid0 = 1'b1;
        data0  = 8'hA5;
        expect_frame(0, 8'hA5, 1'b0, 8'h5A, 1'b0);
        @(negedge clk);
        check("A5 done falls", done0, 0);
        check("A5 single done", done_cnt0, 1);

        // parity frames: 07 -> parity 1, 03 -> parity 0
        valid1 = 1'b1;
        data1  = 8'h07;
        expect_frame(1, 8'h07, 1'b1, 8'h00, 1'b0);
        @(negedge clk);
        check("07 done falls", done1, 0);
        valid1 = 1'b1;
        data1  = 8'h03;
        expect_frame(1, 8'h03, 1'b0, 8'hFF, 1'b0);
        @(negedge clk);
        check("parity done count", done_cnt1, 2);

        // back-to-back 00 then FF with valid held
        repeat (2) @(posedge clk);
        #1;
        dc = done_cnt0;
        valid0 = 1'b1;
        data0  = 8'h00;
        expect_frame(0, 8'h00, 1'b0, 8'hFF, 1'b1);
        expect_frame(0, 8'hFF, 1'b0, 8'h12, 1'b0);
        @(negedge clk);
        check("b2b done count", done_cnt0 - dc, 2);
        check("b2b idle ready", ready0, 1);

        // busy ignore: 55 pulsed during DATA of a 0F frame
        repeat (2) @(posedge clk);
        #1;
        dc = done_cnt0;
        valid0 = 1'b1;
        data0  = 8'h0F;
        fork
            expect_frame(0, 8'h0F, 1'b0, 8'h0F, 1'b0);
            begin
                repeat (12) @(posedge clk);
                #2;
                valid0 = 1'b1;
                data0  = 8'h55;
                @(posedge clk);
                #2;
                valid0 = 1'b0;
            end
        join
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("busy post tx", tx0, 1);
            check("busy post ready", ready0, 1);
        end
        check("busy done count", done_cnt0 - dc, 1);

        // reset during data bit 3 of an A5 frame (bit3 = 0)
        dc = done_cnt0;
        valid0 = 1'b1;
        data0  = 8'hA5;
        @(posedge clk);
        #1 valid0 = 1'b0;
        repeat (17) @(posedge clk);
        #1;
        check("pre-rst tx bit3", tx0, 0);
        check("pre-rst ready", ready0, 0);
        #1 rst = 1'b1;
        #1;
        check("async rst tx", tx0, 1);
        check("async rst ready", ready0, 1);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("post-rst tx", tx0, 1);
            check("post-rst ready", ready0, 1);
        end
        check("rst no done", done_cnt0 - dc, 0);

        // fresh frame after reset release
        @(posedge clk);
        #1;
        valid0 = 1'b1;
        data0  = 8'h3C;
        expect_frame(0, 8'h3C, 1'b0, 8'h00, 1'b0);
        @(negedge clk);
        check("3C done count", done_cnt0 - dc, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/serial_tx.md
# serial_tx

Parallel-to-serial frame transmitter, the sending end of the single-bit serial link whose receiver is built from D flip-flop sampling stages. It accepts a parallel word through a valid/ready handshake, then shifts it out LSB-first on one line, framed by a start bit, an optional even-parity bit and a stop bit. Each bit is held for a parameterised number of clock cycles. It sits between the lab's datapath blocks and the serial output pin or the receiver under test.

## Interface
- DATA_W, 8, payload bits per frame (1..16)
- CLKS_PER_BIT, 4, clock cycles each serial bit is held (>=1)
- PARITY_EN, 0, 1 inserts an even-parity bit after the data bits
- clk  input  1  system clock, rising-edge active
- rst  input  1  reset, asynchronous, active-high
- data_in  input  DATA_W  word to transmit; sampled only on the handshake edge
- valid  input  1  requester has a word on data_in
- ready  output  1  transmitter idle and able to accept a word
- tx  output  1  serial line; idles high
- done  output  1  one-cycle pulse when a frame's stop bit completes

## Operation
- Reset values: tx=1, ready=1, done=0, state IDLE, shift register and counters 0. All outputs are registered.
- States:
  - IDLE: ready=1, tx=1. On valid&&ready at a rising edge, capture data_in into the shift register, compute parity, and go to START.
  - START: tx=0 for CLKS_PER_BIT cycles, then go to DATA.
  - DATA: tx = shift[0]. Shift right every CLKS_PER_BIT cycles. After DATA_W bits, go to PARITY if PARITY_EN, else STOP.
  - PARITY: tx = XOR of the captured word, for CLKS_PER_BIT cycles, then go to STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles, then go to IDLE with done=1 for one cycle.
- ready is 0 in every state except IDLE.
- valid while ready=0 is ignored and data is not captured.
- data_in changes after the handshake edge do not affect the frame in flight.
- Bit counter width is clog2(DATA_W+1). The cycle counter counts 0..CLKS_PER_BIT-1 and wraps to 0 at each bit boundary.
- rst asserted mid-frame:
  - tx returns to 1 and ready to 1 immediately (asynchronous).
  - done stays 0 and the frame is abandoned.
  - There is no resume after rst falls.

## Timing
- Let k be the handshake edge and F=(DATA_W+2+PARITY_EN)*CLKS_PER_BIT.
- Start bit: tx=0 during cycles k+1..k+CLKS_PER_BIT.
- Data bit i: driven during cycles k+1+(i+1)*CLKS_PER_BIT .. k+(i+2)*CLKS_PER_BIT.
- Stop bit occupies the final CLKS_PER_BIT cycles, ending at cycle k+F.
- ready and done rise together after edge k+F. done falls after edge k+F+1.
- Back-to-back: if valid is held high, the next handshake occurs at edge k+F+1. This gives exactly one extra idle-high cycle between frames, so the effective stop length is CLKS_PER_BIT+1.
- CLKS_PER_BIT=1: one cycle per bit, F=DATA_W+2+PARITY_EN.

## Structure
- Package serial_pkg holds:
  - the state encoding constants (IDLE, START, DATA, PARITY, STOP; 3 bits)
  - the idle line level constant (1'b1)
  - the start level constant (1'b0)
  - the default DATA_W and CLKS_PER_BIT
- The matching receiver shares serial_pkg.
- One sub-module, bit_timer:
  - Counts clk cycles up to CLKS_PER_BIT-1 and emits a one-cycle bit_end strobe.
  - Synchronous clear while serial_tx is in IDLE; async reset on rst.
- serial_tx contains the FSM, shift register, bit counter and parity flop.

## Test plan
- Reset: rst=1 for 5 cycles with valid=1 -> tx=1, ready=1, done=0 throughout; no frame starts.
- Single frame, DATA_W=8, CLKS_PER_BIT=4, PARITY_EN=0, data_in=8'hA5:
  - tx per 4-cycle bit is 0,1,0,1,0,0,1,0,1,1.
  - done pulses once, 41 cycles after the handshake edge; ready is low for 40 cycles.
- Parity, PARITY_EN=1, data_in=8'h07 -> parity bit 1 before the stop bit, F=44. Repeat with data_in=8'h03 -> parity bit 0.
- Back-to-back, valid held high with 8'h00 then 8'hFF:
  - Second start bit begins 1 idle cycle after the first done.
  - data_in changes mid-frame do not alter the first frame's bits.
- Busy ignore: pulse valid with 8'h55 during DATA of an 8'h0F frame -> 8'h55 is never transmitted and only one done pulse occurs.
- Reset mid-frame: assert rst during data bit 3 -> tx=1 and ready=1 within the same cycle, no done. A new 8'h3C frame after release transmits correctly.
